// File: rtl/rf_rename_pkg.sv
// Shared widths and constants for the register file / rename slice.
//   NameBus : architectural register name
//   NickBus : ROB nick (rename tag); NoNick marks "value ready"
//   DataBus : register data
package rf_rename_pkg;

  localparam int unsigned RF_REG_NUM = 32;
  localparam int unsigned NAME_BUS_W = 5;
  localparam int unsigned NICK_BUS_W = 5;
  localparam int unsigned DATA_BUS_W = 32;

  // ROB constants: nick 0 is reserved, so usable entries are 1..ROB_DEPTH-1.
  localparam int unsigned ROB_DEPTH  = 1 << NICK_BUS_W;

  typedef logic [NAME_BUS_W-1:0] NameBus;
  typedef logic [NICK_BUS_W-1:0] NickBus;
  typedef logic [DATA_BUS_W-1:0] DataBus;

  localparam NickBus NoNick = '0;

endpackage

// File: rtl/rf_read_port.sv
// One dispatch source-operand lookup.
//   regnm            : source register name
//   reg_tag, reg_dt  : stored tag and data of that register
//   rf_en, rf_nick,
//   rf_dt            : commit stream, for same-cycle bypass
//   dt, nick         : value (valid when nick==0) or producer nick
module rf_read_port
  import rf_rename_pkg::*;
#(
  parameter int unsigned NAME_W = NAME_BUS_W,
  parameter int unsigned NICK_W = NICK_BUS_W,
  parameter int unsigned DATA_W = DATA_BUS_W
) (
  input  logic [NAME_W-1:0] regnm,
  input  logic [NICK_W-1:0] reg_tag,
  input  logic [DATA_W-1:0] reg_dt,
  input  logic              rf_en,
  input  logic [NICK_W-1:0] rf_nick,
  input  logic [DATA_W-1:0] rf_dt,
  output logic [DATA_W-1:0] dt,
  output logic [NICK_W-1:0] nick
);

  always_comb begin
    dt   = '0;
    nick = '0;
    if (regnm == '0) begin
      // x0 always reads as a ready zero
    end else if (reg_tag == NICK_W'(NoNick)) begin
      dt = reg_dt;
    end else if (rf_en && (rf_nick == reg_tag)) begin
      // producer is committing right now: forward its data
      dt = rf_dt;
    end else begin
      nick = reg_tag;
    end
  end

endmodule

// File: rtl/rf_rename.sv
// Architectural register file with per-register rename tags.
//   clk, rst          : clock, synchronous active-high reset
//   rdy               : global ready; state holds when low
//   iclr              : pipeline clear, drops all tags
//   iROB_nick_*       : rename request (destination gets a new nick)
//   iRF_*             : commit write from the ROB
//   iDP_rs*_regnm     : dispatch source lookups
//   oDP_rs*_dt/_nick  : value or producer nick per source
module rf_rename
  import rf_rename_pkg::*;
#(
  parameter int unsigned REG_NUM = RF_REG_NUM,
  parameter int unsigned NAME_W  = NAME_BUS_W,
  parameter int unsigned NICK_W  = NICK_BUS_W,
  parameter int unsigned DATA_W  = DATA_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iclr,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [NAME_W-1:0] iROB_nick_regnm,
  input  logic              iRF_en,
  input  logic [NAME_W-1:0] iRF_rd_regnm,
  input  logic [DATA_W-1:0] iRF_rd_dt,
  input  logic [NICK_W-1:0] iRF_rd_nick,
  input  logic [NAME_W-1:0] iDP_rs1_regnm,
  input  logic [NAME_W-1:0] iDP_rs2_regnm,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  output logic [DATA_W-1:0] oDP_rs2_dt,
  output logic [NICK_W-1:0] oDP_rs2_nick
);

  logic [DATA_W-1:0] data_q [REG_NUM];
  logic [NICK_W-1:0] tag_q  [REG_NUM];

  // Later assignments override earlier ones within the block: commit tag
  // release, then clear, then rename, which gives rename priority over a
  // same-register commit and lets clear discard everything but commit data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (iRF_en && (iRF_rd_regnm != '0)) begin
        data_q[iRF_rd_regnm] <= iRF_rd_dt;
        if (tag_q[iRF_rd_regnm] == iRF_rd_nick)
          tag_q[iRF_rd_regnm] <= NICK_W'(NoNick);
      end
      if (iclr) begin
        for (int unsigned i = 0; i < REG_NUM; i++)
          tag_q[i] <= NICK_W'(NoNick);
      end else if (iROB_nick_en && (iROB_nick_regnm != '0)) begin
        tag_q[iROB_nick_regnm] <= iROB_nick;
      end
    end
  end

  rf_read_port #(
    .NAME_W (NAME_W),
    .NICK_W (NICK_W),
    .DATA_W (DATA_W)
  ) u_rs1 (
    .regnm   (iDP_rs1_regnm),
    .reg_tag (tag_q[iDP_rs1_regnm]),
    .reg_dt  (data_q[iDP_rs1_regnm]),
    .rf_en   (iRF_en),
    .rf_nick (iRF_rd_nick),
    .rf_dt   (iRF_rd_dt),
    .dt      (oDP_rs1_dt),
    .nick    (oDP_rs1_nick)
  );

  rf_read_port #(
    .NAME_W (NAME_W),
    .NICK_W (NICK_W),
    .DATA_W (DATA_W)
  ) u_rs2 (
    .regnm   (iDP_rs2_regnm),
    .reg_tag (tag_q[iDP_rs2_regnm]),
    .reg_dt  (data_q[iDP_rs2_regnm]),
    .rf_en   (iRF_en),
    .rf_nick (iRF_rd_nick),
    .rf_dt   (iRF_rd_dt),
    .dt      (oDP_rs2_dt),
    .nick    (oDP_rs2_nick)
  );

endmodule

// File: tb/tb_rf_rename.sv
// Scoreboard bench for rf_rename: expected lookups are queued when driven
// (posedge+1) and compared on the following negedge.
module tb_rf_rename;
  import rf_rename_pkg::*;

  logic   clk = 1'b0;
  logic   rst, rdy, iclr;
  logic   iROB_nick_en;
  NickBus iROB_nick;
  NameBus iROB_nick_regnm;
  logic   iRF_en;
  NameBus iRF_rd_regnm;
  DataBus iRF_rd_dt;
  NickBus iRF_rd_nick;
  NameBus iDP_rs1_regnm, iDP_rs2_regnm;
  DataBus oDP_rs1_dt, oDP_rs2_dt;
  NickBus oDP_rs1_nick, oDP_rs2_nick;

  always #5 clk = ~clk;

  rf_rename dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .iclr            (iclr),
    .iROB_nick_en    (iROB_nick_en),
    .iROB_nick       (iROB_nick),
    .iROB_nick_regnm (iROB_nick_regnm),
    .iRF_en          (iRF_en),
    .iRF_rd_regnm    (iRF_rd_regnm),
    .iRF_rd_dt       (iRF_rd_dt),
    .iRF_rd_nick     (iRF_rd_nick),
    .iDP_rs1_regnm   (iDP_rs1_regnm),
    .iDP_rs2_regnm   (iDP_rs2_regnm),
    .oDP_rs1_dt      (oDP_rs1_dt),
    .oDP_rs1_nick    (oDP_rs1_nick),
    .oDP_rs2_dt      (oDP_rs2_dt),
    .oDP_rs2_nick    (oDP_rs2_nick)
  );

  typedef struct {
    string  tag;
    DataBus d1;
    NickBus n1;
    DataBus d2;
    NickBus n2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every lookup queued this cycle, away from the clock edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".rs1_dt"},   oDP_rs1_dt,          e.d1);
      chk({e.tag, ".rs1_nick"}, 32'(oDP_rs1_nick),   32'(e.n1));
      chk({e.tag, ".rs2_dt"},   oDP_rs2_dt,          e.d2);
      chk({e.tag, ".rs2_nick"}, 32'(oDP_rs2_nick),   32'(e.n2));
    end
  end

  // Advance one cycle and return all strobes to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    rdy          = 1'b1;
    iclr         = 1'b0;
    iROB_nick_en = 1'b0;
    iRF_en       = 1'b0;
  endtask

  task automatic rename(input NameBus r, input NickBus n);
    iROB_nick_en    = 1'b1;
    iROB_nick_regnm = r;
    iROB_nick       = n;
  endtask

  task automatic commit(input NameBus r, input NickBus n, input DataBus d);
    iRF_en       = 1'b1;
    iRF_rd_regnm = r;
    iRF_rd_nick  = n;
    iRF_rd_dt    = d;
  endtask

  task automatic look(input string tag, input NameBus r1, input DataBus d1, input NickBus n1,
                      input NameBus r2, input DataBus d2, input NickBus n2);
    exp_t e;
    iDP_rs1_regnm = r1;
    iDP_rs2_regnm = r2;
    e.tag = tag; e.d1 = d1; e.n1 = n1; e.d2 = d2; e.n2 = n2;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; iclr = 1'b0;
    iROB_nick_en = 1'b0; iROB_nick = '0; iROB_nick_regnm = '0;
    iRF_en = 1'b0; iRF_rd_regnm = '0; iRF_rd_dt = '0; iRF_rd_nick = '0;
    iDP_rs1_regnm = '0; iDP_rs2_regnm = '0;
    cyc(); cyc();
    rst = 1'b0;

    // 1: reset state
    look("reset", 5'd5, 32'h0, 5'd0, 5'd0, 32'h0, 5'd0);

    // 2: rename then commit with bypass
    cyc(); rename(5'd5, 5'd3);
    look("ren5_same", 5'd5, 32'h0, 5'd0, 5'd0, 32'h0, 5'd0);
    cyc(); look("ren5", 5'd5, 32'h0, 5'd3, 5'd5, 32'h0, 5'd3);
    cyc(); commit(5'd5, 5'd3, 32'hDEADBEEF);
    look("byp5", 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 5'd0);
    cyc(); look("st5", 5'd5, 32'hDEADBEEF, 5'd0, 5'd5, 32'hDEADBEEF, 5'd0);

    // 3: stale commit leaves younger tag
    cyc(); rename(5'd7, 5'd4);
    cyc(); rename(5'd7, 5'd9);
    look("ren7a", 5'd7, 32'h0, 5'd4, 5'd0, 32'h0, 5'd0);
    cyc(); commit(5'd7, 5'd4, 32'h11);
    look("stale7", 5'd7, 32'h0, 5'd9, 5'd5, 32'hDEADBEEF, 5'd0);
    cyc(); commit(5'd7, 5'd9, 32'h22);
    look("byp7", 5'd0, 32'h0, 5'd0, 5'd7, 32'h22, 5'd0);
    cyc(); look("st7", 5'd7, 32'h22, 5'd0, 5'd7, 32'h22, 5'd0);

    // 4: same-cycle commit and rename of x2: rename wins the tag
    cyc(); commit(5'd2, 5'd6, 32'h55); rename(5'd2, 5'd10);
    look("cr2_same", 5'd2, 32'h0, 5'd0, 5'd0, 32'h0, 5'd0);
    cyc(); look("cr2", 5'd2, 32'h0, 5'd10, 5'd7, 32'h22, 5'd0);

    // 5: clear with outstanding renames and a concurrent commit
    cyc(); commit(5'd1, 5'd12, 32'hA1);
    cyc(); commit(5'd3, 5'd13, 32'hA3);
    cyc(); rename(5'd1, 5'd2);
    cyc(); rename(5'd3, 5'd5);
    look("ren1", 5'd1, 32'h0, 5'd2, 5'd2, 32'h0, 5'd10);
    cyc(); iclr = 1'b1; commit(5'd8, 5'd1, 32'h77); rename(5'd4, 5'd7);
    look("clr_same", 5'd1, 32'h0, 5'd2, 5'd3, 32'h0, 5'd5);
    cyc(); look("clr13", 5'd1, 32'hA1, 5'd0, 5'd3, 32'hA3, 5'd0);
    cyc(); look("clr82", 5'd8, 32'h77, 5'd0, 5'd2, 32'h55, 5'd0);
    cyc(); look("clr4", 5'd4, 32'h0, 5'd0, 5'd5, 32'hDEADBEEF, 5'd0);

    // 6: x0 is immutable; rdy low freezes state
    cyc(); rename(5'd0, 5'd7); commit(5'd0, 5'd7, 32'hFF);
    look("x0_same", 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 5'd0);
    cyc(); look("x0", 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 5'd0);
    cyc(); rdy = 1'b0; rename(5'd4, 5'd11); commit(5'd6, 5'd14, 32'h99);
    look("rdy0_rd", 5'd5, 32'hDEADBEEF, 5'd0, 5'd4, 32'h0, 5'd0);
    cyc(); look("rdy0", 5'd4, 32'h0, 5'd0, 5'd6, 32'h0, 5'd0);

    // boundary register / nick: x31 with nick 31
    cyc(); rename(5'd31, 5'd31);
    cyc(); look("ren31", 5'd31, 32'h0, 5'd31, 5'd0, 32'h0, 5'd0);
    cyc(); commit(5'd31, 5'd31, 32'hCAFE);
    look("byp31", 5'd31, 32'hCAFE, 5'd0, 5'd1, 32'hA1, 5'd0);
    cyc(); look("st31", 5'd31, 32'hCAFE, 5'd0, 5'd31, 32'hCAFE, 5'd0);

    // reset again wipes data and tags
    cyc(); rename(5'd9, 5'd8);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    look("rst2", 5'd31, 32'h0, 5'd0, 5'd9, 32'h0, 5'd0);

    cyc(); cyc();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
